// File: rtl/book_pkg.sv
// Shared types and constants for the order book builder: level record,
// side encoding and the price comparison helper used by both sides.
package book_pkg;

    localparam int PRICE_W = 32;
    localparam int QTY_W   = 32;

    typedef enum logic {
        SIDE_ASK = 1'b0,
        SIDE_BID = 1'b1
    } side_e;

    typedef struct packed {
        logic               valid;
        logic [PRICE_W-1:0] price;
        logic [QTY_W-1:0]   qty;
    } level_t;

    // True when price a ranks strictly ahead of price b on the given side
    // (higher is better for bids, lower is better for asks).
    function automatic logic is_better(input logic               is_bid,
                                       input logic [PRICE_W-1:0] a,
                                       input logic [PRICE_W-1:0] b);
        return is_bid ? (a > b) : (a < b);
    endfunction

endpackage

// File: rtl/book_builder_if.sv
// Tick input and top-of-book output bundle for book_builder.
// The slave modport is the book; the master modport is the feed/consumer.
interface book_builder_if #(
    parameter int CNT_W = 16
);
    import book_pkg::*;

    logic [PRICE_W-1:0] s_tick_price;
    logic [QTY_W-1:0]   s_tick_qty;
    logic               s_tick_is_buy;
    logic               s_tick_valid;

    logic [PRICE_W-1:0] m_bid_price;
    logic [QTY_W-1:0]   m_bid_qty;
    logic [PRICE_W-1:0] m_ask_price;
    logic [QTY_W-1:0]   m_ask_qty;
    logic               m_bid_present;
    logic               m_ask_present;
    logic               m_tob_update;
    logic               m_crossed;
    logic [CNT_W-1:0]   m_drop_cnt;

    modport slave (
        input  s_tick_price, s_tick_qty, s_tick_is_buy, s_tick_valid,
        output m_bid_price, m_bid_qty, m_ask_price, m_ask_qty,
               m_bid_present, m_ask_present, m_tob_update, m_crossed, m_drop_cnt
    );

    modport master (
        output s_tick_price, s_tick_qty, s_tick_is_buy, s_tick_valid,
        input  m_bid_price, m_bid_qty, m_ask_price, m_ask_qty,
               m_bid_present, m_ask_present, m_tob_update, m_crossed, m_drop_cnt
    );

endinterface

// File: rtl/book_side.sv
// One side of the book: DEPTH sorted price levels with match / insert /
// delete / shift. Reports the post-tick best level and a drop flag for ticks
// that leave the book unchanged.
module book_side
    import book_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter bit IS_BID = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_valid,
    input  logic [PRICE_W-1:0] tick_price,
    input  logic [QTY_W-1:0]   tick_qty,
    output level_t             next_best,
    output logic               drop
);

    level_t           slots [DEPTH];
    level_t           nxt   [DEPTH];
    level_t           new_lvl;
    logic [DEPTH-1:0] match;
    logic [DEPTH-1:0] worse;
    logic             any_match;
    logic             has_room;
    logic             del_seen;

    assign new_lvl = '{valid: 1'b1, price: tick_price, qty: tick_qty};

    // Classify every slot against the tick: exact price match, or a slot the
    // new level would rank ahead of (empty slots count as worse).
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise
        // always_comb infers a latch for paths that do not assign it.
        any_match = 1'b0;
        has_room  = 1'b0;
        match     = '0;
        worse     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i]  = slots[i].valid && (slots[i].price == tick_price);
            worse[i]  = !slots[i].valid || is_better(IS_BID, tick_price, slots[i].price);
            any_match = any_match | match[i];
            has_room  = has_room | worse[i];
        end
    end

    // Next book contents. Sorting keeps worse[] monotonic, so the first worse
    // slot is the insert point and everything after it moves down one.
    always_comb begin
        nxt      = slots;
        del_seen = 1'b0;
        if (tick_qty != '0) begin
            if (any_match) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (match[i]) nxt[i].qty = tick_qty;
                end
            end else if (has_room) begin
                if (worse[0]) nxt[0] = new_lvl;
                for (int i = 1; i < DEPTH; i++) begin
                    if (worse[i-1])   nxt[i] = slots[i-1];
                    else if (worse[i]) nxt[i] = new_lvl;
                end
            end
        end else if (any_match) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                del_seen = del_seen | match[i];
                if (del_seen) nxt[i] = slots[i+1];
            end
            nxt[DEPTH-1] = '0;
        end
    end

    // A tick is dropped when nothing matches and it neither deletes nor fits.
    assign drop      = tick_valid && !any_match && ((tick_qty == '0) || !has_room);
    assign next_best = tick_valid ? nxt[0] : slots[0];

    // Slot storage.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: this small slot array is a register file, not a RAM, and
            // must be cleared so stale entries never reappear as valid levels.
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else if (tick_valid) begin
            slots <= nxt;
        end
    end

endmodule

// File: rtl/book_builder.sv
// Two-sided order book builder. Routes each tick to its side, registers the
// top of book, detects top changes, flags a crossed book and counts drops.
module book_builder
    import book_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    book_builder_if.slave bus
);

    logic             price_zero;
    logic             bid_tick;
    logic             ask_tick;
    logic             bid_drop;
    logic             ask_drop;
    level_t           bid_next;
    level_t           ask_next;
    level_t           bid_nxt_top;
    level_t           ask_nxt_top;
    level_t           bid_top;
    level_t           ask_top;
    logic             tob_update;
    logic             crossed;
    logic             drop_evt;
    logic [CNT_W-1:0] drop_cnt;

    assign price_zero = (bus.s_tick_price == '0);
    assign bid_tick   = bus.s_tick_valid && !price_zero && (bus.s_tick_is_buy == SIDE_BID);
    assign ask_tick   = bus.s_tick_valid && !price_zero && (bus.s_tick_is_buy == SIDE_ASK);

    book_side #(.DEPTH(DEPTH), .IS_BID(1'b1)) u_bid (
        .clk        (clk),
        .rst        (rst),
        .tick_valid (bid_tick),
        .tick_price (bus.s_tick_price),
        .tick_qty   (bus.s_tick_qty),
        .next_best  (bid_next),
        .drop       (bid_drop)
    );

    book_side #(.DEPTH(DEPTH), .IS_BID(1'b0)) u_ask (
        .clk        (clk),
        .rst        (rst),
        .tick_valid (ask_tick),
        .tick_price (bus.s_tick_price),
        .tick_qty   (bus.s_tick_qty),
        .next_best  (ask_next),
        .drop       (ask_drop)
    );

    // An empty side reports all-zero price/qty.
    assign bid_nxt_top = bid_next.valid ? bid_next : '0;
    assign ask_nxt_top = ask_next.valid ? ask_next : '0;
    assign drop_evt    = (bus.s_tick_valid && price_zero) || bid_drop || ask_drop;

    // Top-of-book registers, change pulse, crossed flag and saturating drop count.
    always_ff @(posedge clk) begin
        if (rst) begin
            bid_top    <= '0;
            ask_top    <= '0;
            tob_update <= 1'b0;
            crossed    <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            bid_top    <= bid_nxt_top;
            ask_top    <= ask_nxt_top;
            tob_update <= (bid_nxt_top != bid_top) || (ask_nxt_top != ask_top);
            crossed    <= bid_nxt_top.valid && ask_nxt_top.valid &&
                          (bid_nxt_top.price >= ask_nxt_top.price);
            if (drop_evt && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign bus.m_bid_price   = bid_top.price;
    assign bus.m_bid_qty     = bid_top.qty;
    assign bus.m_bid_present = bid_top.valid;
    assign bus.m_ask_price   = ask_top.price;
    assign bus.m_ask_qty     = ask_top.qty;
    assign bus.m_ask_present = ask_top.valid;
    assign bus.m_tob_update  = tob_update;
    assign bus.m_crossed     = crossed;
    assign bus.m_drop_cnt    = drop_cnt;

endmodule

// File: tb/tb_book_builder.sv
// Directed bench for book_builder with hand-computed expectations.
module tb_book_builder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    book_builder_if #(.CNT_W(4)) bus ();

    book_builder #(.DEPTH(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic r, input logic v, input logic b,
                         input logic [31:0] p, input logic [31:0] q);
        rst               = r;
        bus.s_tick_valid  = v;
        bus.s_tick_is_buy = b;
        bus.s_tick_price  = p;
        bus.s_tick_qty    = q;
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic b, input logic [31:0] p, input logic [31:0] q);
        drive(1'b0, 1'b1, b, p, q);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bid_price"}, 64'(bus.m_bid_price),   64'd0);
        check({tag, "_bid_qty"},   64'(bus.m_bid_qty),     64'd0);
        check({tag, "_bid_pres"},  64'(bus.m_bid_present), 64'd0);
        check({tag, "_ask_price"}, 64'(bus.m_ask_price),   64'd0);
        check({tag, "_ask_qty"},   64'(bus.m_ask_qty),     64'd0);
        check({tag, "_ask_pres"},  64'(bus.m_ask_present), 64'd0);
        check({tag, "_tob"},       64'(bus.m_tob_update),  64'd0);
        check({tag, "_crossed"},   64'(bus.m_crossed),     64'd0);
        check({tag, "_drop"},      64'(bus.m_drop_cnt),    64'd0);
    endtask

    initial begin
        bus.s_tick_valid  = 1'b0;
        bus.s_tick_is_buy = 1'b0;
        bus.s_tick_price  = '0;
        bus.s_tick_qty    = '0;

        // Reset state
        do_reset();
        check_all_zero("reset");

        // Sorted bid insertion
        tick(1'b1, 32'd100, 32'd10);
        check("s1_t1_price", 64'(bus.m_bid_price), 64'd100);
        check("s1_t1_qty",   64'(bus.m_bid_qty),   64'd10);
        check("s1_t1_pres",  64'(bus.m_bid_present), 64'd1);
        check("s1_t1_tob",   64'(bus.m_tob_update), 64'd1);
        tick(1'b1, 32'd102, 32'd5);
        check("s1_t2_price", 64'(bus.m_bid_price), 64'd102);
        check("s1_t2_qty",   64'(bus.m_bid_qty),   64'd5);
        check("s1_t2_tob",   64'(bus.m_tob_update), 64'd1);
        tick(1'b1, 32'd101, 32'd7);
        check("s1_t3_price", 64'(bus.m_bid_price), 64'd102);
        check("s1_t3_tob",   64'(bus.m_tob_update), 64'd0);
        check("s1_slot1_price", 64'(dut.u_bid.slots[1].price), 64'd101);
        check("s1_slot1_qty",   64'(dut.u_bid.slots[1].qty),   64'd7);
        check("s1_slot2_price", 64'(dut.u_bid.slots[2].price), 64'd100);
        check("s1_slot2_qty",   64'(dut.u_bid.slots[2].qty),   64'd10);
        check("s1_slot3_valid", 64'(dut.u_bid.slots[3].valid), 64'd0);
        check("s1_ask_pres", 64'(bus.m_ask_present), 64'd0);
        // Qty replace on the top level
        tick(1'b1, 32'd102, 32'd9);
        check("s1_repl_qty", 64'(bus.m_bid_qty), 64'd9);
        check("s1_repl_tob", 64'(bus.m_tob_update), 64'd1);
        check("s1_repl_slot1", 64'(dut.u_bid.slots[1].price), 64'd101);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("s1_idle_tob", 64'(bus.m_tob_update), 64'd0);

        // Full side: worse-than-all drop, then better insert evicts worst
        do_reset();
        for (int p = 101; p <= 104; p++) tick(1'b1, 32'(p), 32'd1);
        check("s2_full_top", 64'(bus.m_bid_price), 64'd104);
        tick(1'b1, 32'd99, 32'd1);
        check("s2_drop_cnt", 64'(bus.m_drop_cnt), 64'd1);
        check("s2_drop_tob", 64'(bus.m_tob_update), 64'd0);
        tick(1'b1, 32'd105, 32'd3);
        check("s2_ins_price", 64'(bus.m_bid_price), 64'd105);
        check("s2_ins_qty",   64'(bus.m_bid_qty),   64'd3);
        check("s2_ins_tob",   64'(bus.m_tob_update), 64'd1);
        check("s2_ins_drop",  64'(bus.m_drop_cnt),  64'd1);
        check("s2_slot3_price", 64'(dut.u_bid.slots[3].price), 64'd102);

        // Ask add, delete, delete-miss
        do_reset();
        tick(1'b0, 32'd200, 32'd4);
        check("s3_add_pres",  64'(bus.m_ask_present), 64'd1);
        check("s3_add_price", 64'(bus.m_ask_price),   64'd200);
        check("s3_add_tob",   64'(bus.m_tob_update),  64'd1);
        tick(1'b0, 32'd200, 32'd0);
        check("s3_del_pres",  64'(bus.m_ask_present), 64'd0);
        check("s3_del_price", 64'(bus.m_ask_price),   64'd0);
        check("s3_del_tob",   64'(bus.m_tob_update),  64'd1);
        tick(1'b0, 32'd201, 32'd0);
        check("s3_miss_drop", 64'(bus.m_drop_cnt),   64'd1);
        check("s3_miss_tob",  64'(bus.m_tob_update), 64'd0);

        // Crossed book
        do_reset();
        tick(1'b1, 32'd150, 32'd1);
        check("s4_bid_only", 64'(bus.m_crossed), 64'd0);
        tick(1'b0, 32'd149, 32'd2);
        check("s4_crossed",  64'(bus.m_crossed), 64'd1);
        check("s4_bid_kept", 64'(bus.m_bid_price), 64'd150);
        tick(1'b0, 32'd149, 32'd0);
        check("s4_uncrossed", 64'(bus.m_crossed), 64'd0);

        // Back-to-back ticks with a one-cycle reset mid-stream
        do_reset();
        tick(1'b1, 32'd100, 32'd1);
        tick(1'b0, 32'd110, 32'd1);
        tick(1'b1, 32'd0,   32'd5);
        check("s5_pre_drop", 64'(bus.m_drop_cnt), 64'd1);
        drive(1'b1, 1'b1, 1'b1, 32'd300, 32'd9);
        check_all_zero("s5_rst");
        tick(1'b1, 32'd50, 32'd2);
        check("s5_post_price", 64'(bus.m_bid_price), 64'd50);
        check("s5_post_qty",   64'(bus.m_bid_qty),   64'd2);
        check("s5_post_tob",   64'(bus.m_tob_update), 64'd1);
        check("s5_post_slot1", 64'(dut.u_bid.slots[1].valid), 64'd0);
        check("s5_post_ask",   64'(bus.m_ask_present), 64'd0);

        // Price-0 tick and drop counter saturation (CNT_W = 4)
        do_reset();
        tick(1'b1, 32'd100, 32'd1);
        tick(1'b1, 32'd0, 32'd5);
        check("s6_p0_drop",  64'(bus.m_drop_cnt),   64'd1);
        check("s6_p0_tob",   64'(bus.m_tob_update), 64'd0);
        check("s6_p0_price", 64'(bus.m_bid_price),  64'd100);
        check("s6_p0_slot1", 64'(dut.u_bid.slots[1].valid), 64'd0);
        for (int i = 0; i < 13; i++) tick(1'b0, 32'd0, 32'd3);
        check("s6_drop_14", 64'(bus.m_drop_cnt), 64'd14);
        tick(1'b0, 32'd300, 32'd0);
        check("s6_drop_15", 64'(bus.m_drop_cnt), 64'd15);
        for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 32'd3);
        check("s6_drop_sat", 64'(bus.m_drop_cnt), 64'd15);
        check("s6_book_kept", 64'(bus.m_bid_qty), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/book_builder.md
BOOK_BUILDER -- requirements
Module: book_builder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning price levels held per side (2..8).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the drop counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port s_tick_price  input  32  tick price, unsigned.
REQ-006 SHALL have port s_tick_qty  input  32  tick quantity, unsigned; 0 means delete level.
REQ-007 SHALL have port s_tick_is_buy  input  1  1 = bid side, 0 = ask side.
REQ-008 SHALL have port s_tick_valid  input  1  tick qualifier; no ready, so one tick per cycle is always accepted.
REQ-009 SHALL have port m_bid_price / m_bid_qty  output  32 each  best bid level.
REQ-010 SHALL have port m_ask_price / m_ask_qty  output  32 each  best ask level.
REQ-011 SHALL have port m_bid_present / m_ask_present  output  1 each  side has at least one level.
REQ-012 SHALL have port m_tob_update  output  1  one-cycle pulse when any top-of-book output changes.
REQ-013 SHALL have port m_crossed  output  1  both sides present and best bid >= best ask.
REQ-014 SHALL have port m_drop_cnt  output  CNT_W  saturating count of ticks discarded.

Function
REQ-015 SHALL keep per side DEPTH slots {valid, price, qty}; bids sorted by strictly descending price, asks by strictly ascending price; valid slots contiguous from slot 0.
REQ-016 SHALL process a tick in the cycle s_tick_valid=1; updated book, top outputs, m_crossed and m_tob_update SHALL appear the next cycle (latency 1).
REQ-017 SHALL treat a tick with price 0 as invalid: no book change; m_drop_cnt increments.
REQ-018 SHALL, for qty != 0 and price equal to a valid slot, replace that slot's qty only.
REQ-019 SHALL, for qty != 0 and no price match, insert at the first slot whose price is worse or which is empty, shifting worse slots down one; when the side is full, the worst level is evicted silently (not a drop).
REQ-020 SHALL, for qty != 0, side full, and price worse than every level, discard the tick and increment m_drop_cnt.
REQ-021 SHALL, for qty == 0 and a price match, delete that slot, shift worse slots up one, and clear the last slot's valid.
REQ-022 SHALL, for qty == 0 and no match, leave the book unchanged and increment m_drop_cnt.
REQ-023 SHALL modify only the side selected by s_tick_is_buy; the other side is untouched.
REQ-024 SHALL hold m_drop_cnt at all-ones once saturated.
REQ-025 SHALL drive m_bid_price/qty, m_ask_price/qty from slot 0 when present, else 0.
REQ-026 SHALL pulse m_tob_update iff any of {price, qty, present} of either top changed versus the previous cycle; a deeper-level-only change SHALL NOT pulse it.
REQ-027 SHALL register m_crossed from the post-update book; a crossed book is reported, not corrected.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, clear all slot valid/price/qty and drive every output to 0, including m_drop_cnt, m_tob_update and m_crossed.
REQ-029 SHALL ignore any tick presented in a reset cycle; the first tick in the cycle after rst deasserts SHALL be processed normally.
REQ-030 SHALL, on reset mid-operation, discard the whole book with no m_tob_update pulse for the clearing.

Structure
REQ-031 SHALL take the level record type {valid, price[31:0], qty[31:0]}, the side encoding, and the PRICE_W/QTY_W=32 constants from a shared package, book_pkg.
REQ-032 SHALL implement each side as one instance of sub-module book_side (parameter IS_BID selects sort direction) that performs match/insert/delete/shift and returns a drop flag; book_builder owns the top-of-book registers, change detection, crossed flag and drop counter.

Verification
REQ-033 SHALL cover: bid ticks (100,10), (102,5), (101,7) -> bid slots 102/5, 101/7, 100/10; m_bid_price=102, m_bid_qty=5; m_tob_update pulses once per tick that changes the top (first two ticks only).
REQ-034 SHALL cover: with 4 bids 104..101 full, bid (99,1) -> m_drop_cnt +1, no pulse; bid (105,3) -> 101 evicted, top 105/3, pulse, m_drop_cnt unchanged.
REQ-035 SHALL cover: ask (200,4) then ask (200,0) -> m_ask_present goes 1 then 0, m_ask_price back to 0, two pulses; ask (201,0) on empty side -> m_drop_cnt +1.
REQ-036 SHALL cover: bid (150,1) and ask (149,2) -> m_crossed=1 the cycle after the ask; ask (149,0) -> m_crossed=0.
REQ-037 SHALL cover: back-to-back ticks every cycle with rst asserted for one cycle mid-stream -> all outputs 0 the cycle after reset; the tick in the reset cycle is ignored; the next tick builds from an empty book.
REQ-038 SHALL cover: price-0 tick and CNT_W=4 saturation -> m_drop_cnt stops at 15 after 16 or more drops.
